// File: rtl/fp_mac_pkg.sv
// Shared FP MAC package: arbiter parameter defaults, the adder request
// record and the round-robin pointer helper.
package fp_mac_pkg;

  localparam int ADD_ARB_NREQ  = 4;
  localparam int MAC_ADD_WIDTH = 74;
  localparam int ADD_ARB_IDW   = (ADD_ARB_NREQ > 1) ? $clog2(ADD_ARB_NREQ) : 1;

  // One operand pair together with the id of the requester that sent it.
  typedef struct packed {
    logic [MAC_ADD_WIDTH-1:0] a;
    logic [MAC_ADD_WIDTH-1:0] b;
    logic [ADD_ARB_IDW-1:0]   id;
  } add_req_t;

  // Pointer value after requester g is accepted: the index just past g, wrapping.
  function automatic int rr_next(input int g, input int nreq);
    return (g == nreq - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/add.sv
// Han-Carlson parallel-prefix adder: {cout,sum} = a + b (unsigned).
// Odd bit positions get a Kogge-Stone prefix tree; even positions are
// fixed up from their odd neighbour in one final level.
module add #(
  parameter int width = 74
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] sum,
  output logic             cout
);

  logic [width-1:0] gk;
  logic [width-1:0] pk;
  logic [width-1:0] g_s;
  logic [width-1:0] p_s;
  logic [width-1:0] ng_s;
  logic [width-1:0] np_s;
  logic [width-1:0] carry;

  // Prefix tree: generate/propagate, odd-bit Kogge-Stone, even-bit fixup, sum.
  always_comb begin
    gk    = a & b;
    pk    = a ^ b;
    g_s   = gk;
    p_s   = pk;
    ng_s  = '0;
    np_s  = '0;
    // Odd bits absorb their even neighbour first: span [i:i-1].
    for (int i = 1; i < width; i += 2) begin
      g_s[i] = gk[i] | (pk[i] & gk[i-1]);
      p_s[i] = pk[i] & pk[i-1];
    end
    // Kogge-Stone over odd bits only; span doubles each level.
    for (int d = 2; d < width; d = d * 2) begin
      ng_s = g_s;
      np_s = p_s;
      for (int i = 1; i < width; i += 2) begin
        if (i >= d) begin
          ng_s[i] = g_s[i] | (p_s[i] & g_s[(i >= d) ? i - d : 0]);
          np_s[i] = p_s[i] & p_s[(i >= d) ? i - d : 0];
        end else begin
          ng_s[i] = g_s[i];
          np_s[i] = p_s[i];
        end
      end
      g_s = ng_s;
      p_s = np_s;
    end
    // Even bits take the complete prefix of the odd bit just below.
    for (int i = 2; i < width; i += 2) begin
      g_s[i] = g_s[i] | (p_s[i] & g_s[i-1]);
    end
    carry = {g_s[width-2:0], 1'b0};
    sum   = pk ^ carry;
    cout  = g_s[width-1];
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin controller sharing one `add` instance among NREQ requesters.
// Results come back with the requester id through a registered valid/ready
// port. Define ADD_ARB_OPREG_EN to insert an operand register stage (s1)
// between the arbiter mux and the adder (latency 2 instead of 1).
module add_share_arb
  import fp_mac_pkg::*;
#(
  parameter int WIDTH = MAC_ADD_WIDTH,
  parameter int NREQ  = ADD_ARB_NREQ
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NREQ-1:0]                         req_valid,
  output logic [NREQ-1:0]                         req_ready,
  input  logic [NREQ*WIDTH-1:0]                   req_a,
  input  logic [NREQ*WIDTH-1:0]                   req_b,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [WIDTH-1:0]                        res_sum,
  output logic                                    res_carry,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] res_id,
  output logic                                    busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gid;
  logic [NREQ-1:0]  grant;
  logic             any_valid;
  int               idx;
  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [IDW-1:0]   out_id;
  logic             load_out;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant     = '0;
    gid       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      idx = (idx >= NREQ) ? idx - NREQ : idx;
      if (!any_valid && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
        any_valid  = 1'b1;
      end else begin
        any_valid  = any_valid;
      end
    end
  end

  assign op_a      = req_a[int'(gid)*WIDTH +: WIDTH];
  assign op_b      = req_b[int'(gid)*WIDTH +: WIDTH];
  assign accept    = any_valid & adv & rst_n;
  assign req_ready = grant & {NREQ{adv & rst_n}};

  // Pointer moves just past the accepted requester; frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= IDW'(rr_next(int'(gid), NREQ));
    end else begin
      ptr <= ptr;
    end
  end

`ifdef ADD_ARB_OPREG_EN
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;
  logic             s2_ld;

  assign s2_ld    = s1_valid & (!res_valid | res_ready);
  assign adv      = !s1_valid | s2_ld;
  assign add_a    = s1_a;
  assign add_b    = s1_b;
  assign out_id   = s1_id;
  assign load_out = s2_ld;
  assign busy     = s1_valid | res_valid;

  // Operand stage: captures the granted operands, holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else begin
      s1_valid <= accept | (s1_valid & !s2_ld);
      if (accept) begin
        s1_a  <= op_a;
        s1_b  <= op_b;
        s1_id <= gid;
      end else begin
        s1_a  <= s1_a;
        s1_b  <= s1_b;
        s1_id <= s1_id;
      end
    end
  end
`else
  assign adv      = !res_valid | res_ready;
  assign add_a    = op_a;
  assign add_b    = op_b;
  assign out_id   = gid;
  assign load_out = accept;
  assign busy     = res_valid;
`endif

  add #(.width(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .sum  (sum),
    .cout (cout)
  );

  // Result register: loads a new sum (possibly replacing one being drained), holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else begin
      res_valid <= load_out | (res_valid & !res_ready);
      if (load_out) begin
        res_sum   <= sum;
        res_carry <= cout;
        res_id    <= out_id;
      end else begin
        res_sum   <= res_sum;
        res_carry <= res_carry;
        res_id    <= res_id;
      end
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed phases plus random traffic
// checked cycle by cycle against a queue-based model of the shared adder.
module tb_add_share_arb;

  localparam int W = 74;
  localparam int N = 4;
`ifdef ADD_ARB_OPREG_EN
  localparam int L   = 2;
  localparam int CAP = 2;
`else
  localparam int L   = 1;
  localparam int CAP = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic           res_carry;
  logic [1:0]     res_id;
  logic           busy;

  // Second instance with a non-power-of-two requester count.
  logic [2:0]  v3;
  logic [2:0]  r3;
  logic [23:0] a3;
  logic [23:0] b3;
  logic        rv3;
  logic [7:0]  sum3;
  logic        c3;
  logic [1:0]  id3;
  logic        busy3;

  always #5 clk = ~clk;

  add_share_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id), .busy(busy)
  );

  add_share_arb #(.WIDTH(8), .NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(r3),
    .req_a(a3), .req_b(b3), .res_valid(rv3), .res_ready(1'b1),
    .res_sum(sum3), .res_carry(c3), .res_id(id3), .busy(busy3)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: outstanding results in order, requester mailboxes, pointer.
  typedef struct {
    logic [W:0] val;
    int         id;
    int         t;
  } item_t;
  item_t      q[$];
  bit         pend[N];
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  int         ptr_m = 0;
  int         cyc   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rop(input bit corner);
    logic [95:0] r;
    logic [W-1:0] ones;
    r    = {$urandom, $urandom, $urandom};
    ones = '1;
    if (corner) begin
      case ($urandom_range(3))
        0:       return ones;
        1:       return '0;
        default: return r[W-1:0];
      endcase
    end
    return r[W-1:0];
  endfunction

  // One clock cycle: start at a negedge, drive, check, model the edge, end at next negedge.
  task automatic cycle(input bit rr, input int new_pct, input bit corner);
    bit         hv;
    bit         drain;
    bit         adv;
    int         gsel;
    int         idx;
    logic [N-1:0] exp_rdy;
    item_t      it;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < new_pct)) begin
        pend[i] = 1'b1;
        pa[i]   = rop(corner);
        pb[i]   = rop(corner);
      end
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
    res_ready = rr;
    #1;
    hv    = (q.size() > 0) && ((cyc - q[0].t) >= L - 1);
    drain = hv && rr;
    adv   = (q.size() - (drain ? 1 : 0)) < CAP;
    gsel  = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (gsel < 0 && pend[idx]) gsel = idx;
    end
    exp_rdy = '0;
    if (adv && gsel >= 0) exp_rdy[gsel] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    chk("res_valid", 128'(res_valid), 128'(hv));
    chk("busy", 128'(busy), 128'(q.size() > 0));
    if (hv) begin
      chk("res_sum", 128'(res_sum), 128'(q[0].val[W-1:0]));
      chk("res_carry", 128'(res_carry), 128'(q[0].val[W]));
      chk("res_id", 128'(res_id), 128'(q[0].id));
    end
    @(posedge clk);
    cyc++;
    if (drain) void'(q.pop_front());
    if (exp_rdy != '0) begin
      it.val = {1'b0, pa[gsel]} + {1'b0, pb[gsel]};
      it.id  = gsel;
      it.t   = cyc;
      q.push_back(it);
      pend[gsel] = 1'b0;
      ptr_m      = (gsel + 1) % N;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset from a negedge: outputs must clear at once; model restarts empty.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    #1;
    chk("rst res_valid", 128'(res_valid), 128'(0));
    chk("rst res_sum", 128'(res_sum), 128'(0));
    chk("rst res_carry", 128'(res_carry), 128'(0));
    chk("rst res_id", 128'(res_id), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst req_ready", 128'(req_ready), 128'(0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ptr_m = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    v3        = '0;
    a3        = '0;
    b3        = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    @(negedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0);

    // Single request from requester 2: all-ones + 1 wraps to zero with carry.
    pend[2] = 1'b1;
    pa[2]   = '1;
    pb[2]   = 74'd1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0);

    // All requesters continuously valid from pointer 0, no backpressure.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 100, 1'b0);

    // Five-cycle output stall with everyone valid, then release.
    for (int i = 0; i < 5; i++) cycle(1'b0, 100, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 100, 1'b0);

    // Random traffic and random backpressure.
    for (int i = 0; i < 400; i++) cycle($urandom_range(3) != 0, 40, 1'b1);

    // Fill the pipeline under stall, then reset mid-operation.
    for (int i = 0; i < 4; i++) cycle(1'b0, 100, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 0, 1'b0);

    // NREQ=3: move pointer to 2, then requesters 2 and 0 compete.
    v3        = 3'b010;
    a3[8 +: 8] = 8'h10;
    b3[8 +: 8] = 8'h01;
    #1;
    chk("n3 first grant", 128'(r3), 128'(3'b010));
    @(posedge clk);
    @(negedge clk);
    v3         = 3'b101;
    a3[16 +: 8] = 8'h20;
    a3[0 +: 8]  = 8'h30;
    #1;
    chk("n3 grant from ptr2", 128'(r3), 128'(3'b100));
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b001;
    #1;
    chk("n3 wrap grant", 128'(r3), 128'(3'b001));
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b111;
    #1;
    chk("n3 ptr ends at 1", 128'(r3), 128'(3'b010));
    @(posedge clk);
    @(negedge clk);
    v3 = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
